// File: rtl/mem_arb_types.sv
// rtl/mem_arb_types.sv - shared arbiter state/owner enums and starvation default
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating fetch-wait counter, forces a fetch win at MAX
module starve_counter
  import mem_arb_types::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_fetch
);

  localparam logic [2:0] MAX_C = 3'(MAX);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt) begin
      cnt_d = 3'd0;
    end else if (if_req && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fetch = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one synchronous RAM port
// Optional fetch starvation guard: ARB_STARVE_GUARD_EN
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [15:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              a1_q, a1_d;
  logic              we_q, we_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              force_fetch;
  logic              fetch_wins;

`ifdef ARB_STARVE_GUARD_EN
  starve_counter #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_gnt     (if_gnt_q),
    .force_fetch(force_fetch)
  );
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_fetch = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[0], dm_addr[1:0]};

  assign fetch_wins = if_req && (!dm_req || force_fetch);

  // Read data is live from the RAM during RESP and held from the flop otherwise.
  assign if_rdata  = if_valid_q ? (a1_q ? mem_rdata[31:16] : mem_rdata[15:0]) : if_rdata_q;
  assign dm_rdata  = dm_valid_q ? (we_q ? '0 : mem_rdata) : dm_rdata_q;
  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    a1_d        = a1_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    mem_we_d    = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    case (state_q)
      IDLE, RESP: begin
        if (if_req || dm_req) begin
          state_d = ACCESS;
          if (fetch_wins) begin
            owner_d    = OWN_IF;
            a1_d       = if_addr[1];
            we_d       = 1'b0;
            mem_addr_d = {2'b00, if_addr[ADDR_W-1:2]};
            if_gnt_d   = 1'b1;
          end else begin
            owner_d     = OWN_DM;
            we_d        = dm_we;
            mem_addr_d  = {2'b00, dm_addr[ADDR_W-1:2]};
            mem_wdata_d = dm_wdata;
            mem_we_d    = dm_we;
            dm_gnt_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d    = RESP;
        if_valid_d = (owner_q == OWN_IF);
        dm_valid_d = (owner_q == OWN_DM);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      a1_q        <= 1'b0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      a1_q        <= a1_d;
      we_q        <= we_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int SMAX = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_valid;
  logic [15:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_valid;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5a, b + 8'd3};
  endfunction

  // Single-port synchronous RAM seen by the arbiter; contents restored on reset.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic idle_inputs;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
  endtask

  task automatic do_reset;
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic dm_write_raw(input logic [31:0] a, input logic [31:0] d);
    dm_req = 1; dm_we = 1; dm_addr = a; dm_wdata = d;
    @(negedge clk);
    dm_req = 0; dm_we = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 0;
    idle_inputs();
    @(negedge clk);
    n_total++; if ({if_gnt, if_valid, dm_gnt, dm_valid, mem_we} !== 5'b0)
      $display("FAIL reset_pulses got=%b exp=00000", {if_gnt, if_valid, dm_gnt, dm_valid, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_mem got=%h/%h exp=0/0", mem_addr, mem_wdata); else n_pass++;
    n_total++; if (if_rdata !== 16'h0 || dm_rdata !== 32'h0)
      $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); else n_pass++;
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    do_reset();
    dm_write_raw(32'h100, 32'hBEEF_1234);
    if_req = 1; if_addr = 32'h0000_0102;
    @(negedge clk);
    n_total++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0)
      $display("FAIL fetch_gnt got=%b%b exp=10", if_gnt, dm_gnt); else n_pass++;
    n_total++; if (mem_addr !== 32'h40 || mem_we !== 1'b0)
      $display("FAIL fetch_mem got=%h we=%b exp=40 we=0", mem_addr, mem_we); else n_pass++;
    if_req = 0;
    @(negedge clk);
    n_total++; if (if_valid !== 1'b1 || if_gnt !== 1'b0)
      $display("FAIL fetch_valid got=%b gnt=%b exp=1 gnt=0", if_valid, if_gnt); else n_pass++;
    n_total++; if (if_rdata !== 16'hBEEF)
      $display("FAIL fetch_rdata got=%h exp=beef", if_rdata); else n_pass++;
    @(negedge clk);
    n_total++; if (if_valid !== 1'b0 || if_rdata !== 16'hBEEF)
      $display("FAIL fetch_hold got=%b/%h exp=0/beef", if_valid, if_rdata); else n_pass++;
  endtask

  task automatic test_data_write;
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_total++; if (dm_gnt !== 1'b1 || mem_we !== 1'b1)
      $display("FAIL wr_gnt got=%b we=%b exp=1 we=1", dm_gnt, mem_we); else n_pass++;
    n_total++; if (mem_addr !== 32'h4 || mem_wdata !== 32'hCAFE_F00D)
      $display("FAIL wr_mem got=%h/%h exp=4/cafef00d", mem_addr, mem_wdata); else n_pass++;
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    n_total++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0 || mem_we !== 1'b0)
      $display("FAIL wr_resp got=%b/%h we=%b exp=1/0 we=0", dm_valid, dm_rdata, mem_we); else n_pass++;
    dm_req = 1; dm_we = 0; dm_addr = 32'h13;
    @(negedge clk);
    n_total++; if (dm_gnt !== 1'b1 || mem_addr !== 32'h4)
      $display("FAIL rd_gnt got=%b/%h exp=1/4", dm_gnt, mem_addr); else n_pass++;
    dm_req = 0;
    @(negedge clk);
    n_total++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hCAFE_F00D)
      $display("FAIL rd_data got=%b/%h exp=1/cafef00d", dm_valid, dm_rdata); else n_pass++;
  endtask

  task automatic test_priority;
    do_reset();
    if_req = 1; if_addr = 32'h8; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    @(negedge clk);
    n_total++; if ({dm_gnt, if_gnt} !== 2'b10)
      $display("FAIL prio_first got=%b exp=10", {dm_gnt, if_gnt}); else n_pass++;
    dm_req = 0;
    @(negedge clk);
    n_total++; if ({dm_valid, if_gnt, if_valid} !== 3'b100)
      $display("FAIL prio_resp got=%b exp=100", {dm_valid, if_gnt, if_valid}); else n_pass++;
    @(negedge clk);
    n_total++; if ({if_gnt, dm_gnt, dm_valid} !== 3'b100)
      $display("FAIL prio_fetch got=%b exp=100", {if_gnt, dm_gnt, dm_valid}); else n_pass++;
    if_req = 0;
    @(negedge clk);
    n_total++; if (if_valid !== 1'b1 || if_rdata !== init_word(2)[15:0])
      $display("FAIL prio_fdata got=%b/%h exp=1/%h", if_valid, if_rdata, init_word(2)[15:0]); else n_pass++;
  endtask

  task automatic test_starvation;
    int since;
    bit x_if, x_dm;
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h40; if_req = 1; if_addr = 32'h4;
    since = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      since++;
      x_if = GUARD && if_req && (since == SMAX + 1);
      x_dm = (i % 2 == 1) && !x_if;
      n_total++; if ({if_gnt, dm_gnt} !== {x_if, x_dm})
        $display("FAIL starve_c%0d got=%b exp=%b", i, {if_gnt, dm_gnt}, {x_if, x_dm}); else n_pass++;
      if (x_if) if_req = 0;
      else if (!if_req) begin if_req = 1; since = 0; end
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_during_access;
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'h1234_5678;
    @(negedge clk);
    n_total++; if (dm_gnt !== 1'b1 || mem_we !== 1'b1)
      $display("FAIL rst_acc_pre got=%b we=%b exp=1 we=1", dm_gnt, mem_we); else n_pass++;
    reset = 0; dm_req = 0; dm_we = 0;
    @(negedge clk);
    n_total++; if ({mem_we, dm_valid, dm_gnt, if_gnt, if_valid} !== 5'b0)
      $display("FAIL rst_acc_pulses got=%b exp=00000", {mem_we, dm_valid, dm_gnt, if_gnt, if_valid}); else n_pass++;
    n_total++; if ({mem_addr, mem_wdata, dm_rdata, if_rdata} !== 112'h0)
      $display("FAIL rst_acc_zero got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, dm_rdata, if_rdata); else n_pass++;
    reset = 1;
    @(negedge clk);
    n_total++; if ({mem_we, dm_valid, dm_gnt} !== 3'b0)
      $display("FAIL rst_acc_idle got=%b exp=000", {mem_we, dm_valid, dm_gnt}); else n_pass++;
  endtask

  // Transaction-level model: an arbitration slot opens every 2 cycles at most,
  // grant follows in the next cycle and the response one cycle later.
  task automatic test_random;
    int cyc, e, free_at, gnt_cyc, starve;
    bit have_tx, tx_dm, tx_we, fetch_win, prev_if_gnt;
    bit x_if_gnt, x_dm_gnt, x_if_val, x_dm_val, x_we;
    logic [31:0] tx_addr, tx_wdata, tx_rdata, w, hold_dm;
    logic [15:0] hold_if;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    cyc = 0; free_at = 0; gnt_cyc = -10; starve = 0; have_tx = 0; tx_dm = 0; tx_we = 0;
    tx_addr = 0; tx_wdata = 0; tx_rdata = 0; hold_dm = 0; hold_if = 0;
    for (int n = 0; n < 500; n++) begin
      e = cyc + 1;
      prev_if_gnt = have_tx && !tx_dm && (gnt_cyc == cyc);
      if (e >= free_at && (if_req || dm_req)) begin
        fetch_win = if_req && (!dm_req || (GUARD && starve >= SMAX));
        have_tx = 1; gnt_cyc = e; free_at = e + 2; tx_dm = !fetch_win;
        if (fetch_win) begin
          tx_addr = if_addr; tx_we = 0;
          w = ref_mem[if_addr[9:2]];
          tx_rdata = if_addr[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
        end else begin
          tx_addr = dm_addr; tx_we = dm_we; tx_wdata = dm_wdata;
          if (dm_we) begin ref_mem[dm_addr[9:2]] = dm_wdata; tx_rdata = 0; end
          else tx_rdata = ref_mem[dm_addr[9:2]];
        end
      end
      if (prev_if_gnt) starve = 0;
      else if (if_req && starve < SMAX) starve++;
      @(negedge clk);
      cyc = e;
      x_if_gnt = have_tx && !tx_dm && (gnt_cyc == cyc);
      x_dm_gnt = have_tx && tx_dm && (gnt_cyc == cyc);
      x_if_val = have_tx && !tx_dm && (gnt_cyc + 1 == cyc);
      x_dm_val = have_tx && tx_dm && (gnt_cyc + 1 == cyc);
      x_we = x_dm_gnt && tx_we;
      if (x_if_val) hold_if = tx_rdata[15:0];
      if (x_dm_val) hold_dm = tx_rdata;
      n_total++; if ({if_gnt, dm_gnt, if_valid, dm_valid, mem_we} !== {x_if_gnt, x_dm_gnt, x_if_val, x_dm_val, x_we})
        $display("FAIL rnd_ctl c%0d got=%b exp=%b", cyc, {if_gnt, dm_gnt, if_valid, dm_valid, mem_we},
                 {x_if_gnt, x_dm_gnt, x_if_val, x_dm_val, x_we}); else n_pass++;
      n_total++; if (if_rdata !== hold_if || dm_rdata !== hold_dm)
        $display("FAIL rnd_rdata c%0d got=%h/%h exp=%h/%h", cyc, if_rdata, dm_rdata, hold_if, hold_dm); else n_pass++;
      if (x_if_gnt || x_dm_gnt) begin
        n_total++; if (mem_addr !== (tx_addr >> 2))
          $display("FAIL rnd_addr c%0d got=%h exp=%h", cyc, mem_addr, tx_addr >> 2); else n_pass++;
      end
      if (x_we) begin
        n_total++; if (mem_wdata !== tx_wdata)
          $display("FAIL rnd_wdata c%0d got=%h exp=%h", cyc, mem_wdata, tx_wdata); else n_pass++;
      end
      if (if_req && !x_if_gnt) begin
        if ($urandom_range(15) == 0) if_req = 0;
      end else begin
        if_req = ($urandom_range(2) == 0);
        if_addr = 32'($urandom_range(255)) & ~32'h1;
      end
      if (dm_req && !x_dm_gnt) begin
        if ($urandom_range(15) == 0) dm_req = 0;
      end else begin
        dm_req = ($urandom_range(2) == 0);
        dm_we = 1'($urandom_range(1));
        dm_addr = 32'($urandom_range(255));
        dm_wdata = $urandom;
      end
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fetch();
    test_data_write();
    test_priority();
    test_starvation();
    test_reset_during_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line: ADDR_W, 32, byte-address width; DATA_W, 32, memory word width; STARVE_MAX, 4, fetch wait cycles before forced fetch grant.
REQ-002 clk  input  1  single clock, all state on rising edge; reset is synchronous and active-low.
REQ-003 reset  input  1  synchronous active-low reset.
REQ-004 if_req  input  1  fetch read request, held until if_gnt.
REQ-005 if_addr  input  ADDR_W  fetch byte address, halfword aligned.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 if_valid  output  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  output  16  fetched instruction halfword.
REQ-009 dm_req, dm_we  input  1 each  data request and write qualifier, held until dm_gnt.
REQ-010 dm_addr, dm_wdata  input  ADDR_W, DATA_W  data byte address (bits [1:0] ignored) and write data.
REQ-011 dm_gnt, dm_valid  output  1 each  data accept pulse and completion pulse.
REQ-012 dm_rdata  output  DATA_W  data read word; 0 on write completion.
REQ-013 mem_addr  output  ADDR_W  word address to single-port synchronous RAM.
REQ-014 mem_wdata, mem_we  output  DATA_W, 1  RAM write data and write strobe.
REQ-015 mem_rdata  input  DATA_W  RAM read data, valid the cycle after the address cycle.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; one transaction in flight at most.
REQ-017 IDLE or RESP with any request sampled: register winner, address, we, wdata; go ACCESS; else go/stay IDLE.
REQ-018 Winner: dm when both request, unless the starvation guard forces fetch (REQ-027).
REQ-019 ACCESS: winner's gnt high exactly this cycle; mem_addr = {2'b0, addr[ADDR_W-1:2]}; mem_we = latched we for data, 0 for fetch; next state RESP.
REQ-020 RESP: winner's valid high exactly this cycle; dm_rdata = mem_rdata on read, 0 on write; if_rdata = latched addr[1] ? mem_rdata[31:16] : mem_rdata[15:0].
REQ-021 Latency: request sampled at edge N -> gnt during cycle N+1 -> valid during cycle N+2; back-to-back throughput one access per 2 cycles.
REQ-022 Request still asserted during RESP is a new request and arbitrates in RESP (REQ-017).
REQ-023 Outside ACCESS: mem_we = 0 and mem_addr/mem_wdata hold last value; outside RESP: if_rdata, dm_rdata hold last value; valid/gnt pulses never overlap between ports.
REQ-024 Request deasserted before gnt is dropped without side effect.

Reset
REQ-025 reset low at an edge: state IDLE; if_gnt, if_valid, dm_gnt, dm_valid, mem_we = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve counter = 0.
REQ-026 Reset during ACCESS or RESP abandons the access: no gnt/valid after the reset edge; mem_we low from the first cycle after the reset edge.

Configuration
REQ-027 ARB_STARVE_GUARD_EN defined: 3-bit counter increments each cycle if_req is high and fetch not granted, saturates at STARVE_MAX, clears on fetch grant; at STARVE_MAX fetch wins arbitration over dm.
REQ-028 ARB_STARVE_GUARD_EN undefined: no counter; strict dm priority; fetch may starve indefinitely.

Structure
REQ-029 Arbiter state enum (IDLE/ACCESS/RESP) and owner enum (OWN_IF/OWN_DM) live in shared package mem_arb_types; STARVE_MAX default also defined there.
REQ-030 Starvation counter is sub-module starve_counter, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-031 Fetch only: if_req, if_addr=0x0000_0102, mem_rdata=0xBEEF_1234 -> if_gnt next cycle with mem_addr=0x40, if_valid following cycle with if_rdata=0xBEEF.
REQ-032 Data write: dm_req, dm_we, dm_addr=0x10, dm_wdata=0xCAFE_F00D -> one-cycle mem_we=1, mem_addr=0x4, mem_wdata=0xCAFE_F00D; dm_valid next cycle, dm_rdata=0.
REQ-033 Simultaneous if_req and dm_req, guard off -> dm served first; fetch gnt 2 cycles after dm_gnt.
REQ-034 Guard on, dm_req held high continuously, if_req high -> fetch granted once counter reaches 4; counter returns to 0 after the grant.
REQ-035 reset driven low during ACCESS of a data write -> mem_we low the cycle after the reset edge, no dm_valid, all outputs 0, state IDLE.
